// File: rtl/switch_word_debouncer.sv
// switch_word_debouncer: two-flop synchroniser plus whole-word debounce for the
// board slide-switch word. Only a word that has held unchanged for the full hold
// window reaches word_out, so a partially switched word is never seen downstream.
// The outputs are the committed word, a "valid since reset" level, a 1-cycle change
// strobe and a settle-in-progress flag.
// Optional build macro: DEBOUNCE_FAST_SIM_EN forces the hold window to 16 cycles,
// whatever STABLE_CYCLES is, so that long top-level simulations finish quickly.
module switch_word_debouncer #(
    parameter int unsigned WIDTH         = 7,
    parameter int unsigned STABLE_CYCLES = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             word_stb,
    output logic             busy
);

    // Effective hold window: the number of edges the synchronised word must stay unchanged.
`ifdef DEBOUNCE_FAST_SIM_EN
    localparam int unsigned HOLD_CYCLES = 16;
`else
    localparam int unsigned HOLD_CYCLES = STABLE_CYCLES;
`endif

    // The counter must cover both the nominal window and the effective window.
    localparam int unsigned CNT_W_NOM  = $clog2(STABLE_CYCLES);
    localparam int unsigned CNT_W_HOLD = $clog2(HOLD_CYCLES);
    localparam int unsigned CNT_W_MAX  = (CNT_W_NOM > CNT_W_HOLD) ? CNT_W_NOM : CNT_W_HOLD;
    localparam int unsigned CNT_W      = (CNT_W_MAX > 0) ? CNT_W_MAX : 1;

    // The commit fires at this count: HOLD_CYCLES edges after the settle window opened.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    // Reject illegal hold lengths at elaboration time.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 32'd16777216) begin : g_bad_stable
        $error("switch_word_debouncer: STABLE_CYCLES must be in 2..2^24");
    end

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STABLE = 2'd2
    } state_e;

    // Synchroniser stages. Only sync2_q is used past this point.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Debounce state
    state_e           state_q,      state_d;
    logic [WIDTH-1:0] cand_q,       cand_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] word_out_q,   word_out_d;
    logic             word_valid_q, word_valid_d;
    logic             word_stb_q,   word_stb_d;
    logic             busy_q,       busy_d;

    // Decoded conditions for the current edge
    logic word_change;
    logic commit;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    // State and output registers. Reset abandons any settle in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cand_q       <= '0;
            cnt_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_stb_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_stb_q   <= word_stb_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: restart on any change, count while steady, commit at the end of the window.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        word_stb_d   = 1'b0;

        word_change = (sync2_q != cand_q);
        commit      = (state_q != ST_STABLE) && !word_change && (cnt_q == CNT_LAST);

        if (word_change) begin
            // Any movement, from any state, opens a fresh settle window.
            cand_d  = sync2_q;
            cnt_d   = '0;
            state_d = ST_SETTLE;
        end else if (commit) begin
            state_d = ST_STABLE;
            // A bounce back to the committed word settles quietly, with no strobe.
            if (!word_valid_q || (cand_q != word_out_q)) begin
                word_out_d   = cand_q;
                word_valid_d = 1'b1;
                word_stb_d   = 1'b1;
            end
        end else if ((state_q != ST_STABLE) && (cnt_q != CNT_LAST)) begin
            // Saturating count: it is held in STABLE and never wraps.
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d = (state_d == ST_SETTLE);
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_stb   = word_stb_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_switch_word_debouncer.sv
// Testbench for switch_word_debouncer: directed scenarios followed by randomized
// switch activity. A timestamp-based reference model pushes the expected committed
// words into a queue, and a monitor pops and compares them whenever the strobe fires.
module tb_switch_word_debouncer;

    localparam int unsigned W = 7;
    localparam int unsigned S = 8;
`ifdef DEBOUNCE_FAST_SIM_EN
    localparam int unsigned HOLD = 16;
`else
    localparam int unsigned HOLD = S;
`endif
    localparam int LAT = int'(HOLD) + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_in = 7'b1100110;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_stb;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    switch_word_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_stb   (word_stb),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model, expressed as time since the synchronised word last moved.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_cand = '0, m_out = '0;
    bit           m_valid = 1'b0;
    bit           m_settling = 1'b0;
    bit           m_done = 1'b0;
    longint       edge_n = 0;
    longint       m_last_move = 0;

    initial begin : model
        logic [W-1:0] seen;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_cand = '0; m_out = '0;
                m_valid = 1'b0; m_settling = 1'b0; m_done = 1'b0;
                m_last_move = edge_n;
                exp_q.delete();
            end else begin
                seen = m_s2;
                m_s2 = m_s1;
                m_s1 = sw_in;
                if (seen != m_cand) begin
                    m_cand = seen;
                    m_last_move = edge_n;
                    m_settling = 1'b1;
                    m_done = 1'b0;
                end else if (!m_done && (edge_n - m_last_move == longint'(HOLD))) begin
                    m_done = 1'b1;
                    m_settling = 1'b0;
                    if (!m_valid || m_cand != m_out) begin
                        m_out = m_cand;
                        m_valid = 1'b1;
                        exp_q.push_back(m_cand);
                    end
                end
            end
        end
    end

    // Monitor: compares the level outputs every cycle and pops the scoreboard on each strobe.
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            chk("word_out",   32'(word_out),   32'(m_out));
            chk("word_valid", 32'(word_valid), 32'(m_valid));
            chk("busy",       32'(busy),       32'(m_settling));
            if (word_stb || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_stb", 32'(word_stb), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stb_present", 32'(word_stb), 32'd1);
                    if (word_stb) chk("stb_word", 32'(word_out), 32'(e));
                end
            end
        end
    end

    // Counts cycles from the next edge until word_stb is seen; returns bound if none.
    task automatic measure_stb(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(posedge clk);
            @(negedge clk);
            if (word_stb) return;
            n++;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        logic [W-1:0] v;
        // Reset held for two edges with a non-zero switch word.
        rst   = 1'b1;
        sw_in = 7'b1100110;
        repeat (2) @(negedge clk);
        chk("reset_word_out", 32'(word_out), 32'd0);
        chk("reset_valid",    32'(word_valid), 32'd0);
        rst = 1'b0;

        // First word after reset release.
        measure_stb(LAT + 20, n);
        chk("first_word_latency", 32'(n), 32'(LAT));
        chk("first_word_value",   32'(word_out), 32'(7'b1100110));

        // Single-bit change.
        sw_in = 7'b0100110;
        measure_stb(LAT + 20, n);
        chk("change_latency", 32'(n), 32'(LAT));
        chk("change_value",   32'(word_out), 32'(7'b0100110));

        // Glitch on bit 5 for 5 cycles, then restore: no strobe expected.
        repeat (3) @(negedge clk);
        sw_in = 7'b0100110 ^ 7'b0100000;
        repeat (5) @(negedge clk);
        sw_in = 7'b0100110;
        measure_stb(LAT + 10, n);
        chk("glitch_no_stb", 32'(n), 32'(LAT + 10));

        // Pulse of exactly HOLD cycles never commits; a pulse of HOLD+1 does.
        sw_in = 7'b0000001;
        repeat (HOLD) @(negedge clk);
        sw_in = 7'b0100110;
        measure_stb(LAT + 10, n);
        chk("pulse_hold_no_stb", 32'(n), 32'(LAT + 10));
        sw_in = 7'b0000001;
        repeat (HOLD + 1) @(negedge clk);
        sw_in = 7'b0100110;
        repeat (LAT + 10) @(negedge clk);

        // Reset in the middle of a settle.
        sw_in = 7'b1010101;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_valid", 32'(word_valid), 32'd0);
        rst = 1'b0;
        measure_stb(LAT + 20, n);
        chk("midreset_latency", 32'(n), 32'(LAT));
        chk("midreset_value",   32'(word_out), 32'(7'b1010101));

        // Randomized switch activity, including staggered bit flips and occasional resets.
        for (int i = 0; i < 400; i++) begin
            v = sw_in;
            case ($urandom_range(0, 3))
                0: v = W'($urandom);
                1: v[$urandom_range(0, W - 1)] ^= 1'b1;
                2: begin
                    v[$urandom_range(0, W - 1)] ^= 1'b1;
                    sw_in = v;
                    @(negedge clk);
                    v[$urandom_range(0, W - 1)] ^= 1'b1;
                end
                default: v = sw_in;
            endcase
            sw_in = v;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, HOLD + 4)) @(negedge clk);
        end

        repeat (LAT + 5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
